// File: rtl/mux4_arb_pkg.sv
// Shared constants for the round-robin 4:1 mux arbiter.
package mux4_arb_pkg;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDXW    = 2;
  localparam logic        ST_IDLE = 1'b0;
  localparam logic        ST_FULL = 1'b1;
  localparam logic [1:0]  PTR_RST = 2'd3;
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way priority pick, searching start, start+1, start+2, start+3.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] start,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDXW-1:0]   off;

  // Rotate so the start position lands at bit 0, then pick the lowest set bit.
  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[NREQ-1:0];
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    gnt_idx = start + off;
    any     = |req;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selects into a valid/ready output register.
// Optional burst lock port enabled by defining MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  input  logic [DW-1:0]   data0,
  input  logic [DW-1:0]   data1,
  input  logic [DW-1:0]   data2,
  input  logic [DW-1:0]   data3,
  output logic [NREQ-1:0] ack,
  output logic            s0,
  output logic            s1,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] start;
  logic [IDXW-1:0] gnt_idx;
  logic            any;
  logic            slot_free;
  logic            capture;
  logic [DW-1:0]   win_data;

`ifdef MUX4_ARB_LOCK_EN
  logic lock_q;
  // A locked winner searches itself first on the next arbitration.
  assign start = lock_q ? ptr : ptr + 2'd1;
`else
  assign start = ptr + 2'd1;
`endif

  rr_pick4 u_pick (
    .req     (req),
    .start   (start),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign slot_free = (state == ST_IDLE) || out_ready;
  assign capture   = slot_free && any && !reset;
  assign out_valid = state;

  // Selects and ack only pulse in a capture cycle.
  always_comb begin
    ack = '0;
    s0  = 1'b0;
    s1  = 1'b0;
    if (capture) begin
      ack = NREQ'(1) << gnt_idx;
      s0  = gnt_idx[0];
      s1  = gnt_idx[1];
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      out_data <= '0;
      out_src  <= 2'd0;
      ptr      <= PTR_RST;
`ifdef MUX4_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else if (capture) begin
      state    <= ST_FULL;
      out_data <= win_data;
      out_src  <= gnt_idx;
      ptr      <= gnt_idx;
`ifdef MUX4_ARB_LOCK_EN
      lock_q   <= lock[gnt_idx];
`endif
    end else if (state == ST_FULL && out_ready) begin
      state <= ST_IDLE;
    end
  end

endmodule
